// File: rtl/sap1_program_loader.sv
// sap1_program_loader
//   Streams a program into the SAP-1 core's RAM over a valid/ready handshake,
//   zero-fills whatever the stream did not cover, and holds the core in reset
//   until the RAM is completely defined.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   load_req             start a load (honoured in IDLE and RUN)
//   start_req            run current RAM contents without loading (IDLE only)
//   load_end             end the stream early; remaining words are zero-filled
//   in_data/in_valid     program byte stream
//   in_ready             high whenever a byte can be accepted (LOAD state)
//   core_hlt             halt flag from the core, returns to IDLE
//   ram_we/addr/wdata    registered RAM write port
//   core_rst             registered active-high core reset (low only in RUN)
//   running              registered, high while in RUN
//   done                 one-cycle pulse when a load completes
//   byte_count           bytes accepted during the last load, 0..DEPTH

module sap1_program_loader #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              start_req,
    input  logic              load_end,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              core_hlt,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              core_rst,
    output logic              running,
    output logic              done,
    output logic [ADDR_W:0]   byte_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [ADDR_W:0]   count_next;
    logic              accept;
    logic              last_accept;

    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              done_d;
    logic              running_d;
    logic              core_rst_d;

    assign in_ready    = (state == LOAD);
    assign accept      = in_valid & in_ready;
    // The DEPTH-th accept: ptr has already wrapped, so the count decides.
    assign last_accept = accept && (byte_count == LAST_COUNT);

    // State register plus the registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            byte_count <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            core_rst   <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            byte_count <= count_next;
            ram_we     <= we_d;
            ram_addr   <= addr_d;
            ram_wdata  <= wdata_d;
            core_rst   <= core_rst_d;
            running    <= running_d;
            done       <= done_d;
        end
    end

    // Next-state and pointer/count update.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        count_next = byte_count;
        unique case (state)
            IDLE: begin
                if (load_req) begin
                    state_next = LOAD;
                    ptr_next   = '0;
                    count_next = '0;
                end else if (start_req) begin
                    state_next = RUN;
                end
            end
            LOAD: begin
                if (accept) begin
                    ptr_next   = ptr + 1'b1;
                    count_next = byte_count + 1'b1;
                end
                // A byte accepted alongside load_end is written first; FILL
                // then begins at the incremented pointer.
                if (last_accept) begin
                    state_next = RUN;
                end else if (load_end) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                ptr_next = ptr + 1'b1;
                if (ptr == LAST_ADDR) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (load_req) begin
                    state_next = LOAD;
                    ptr_next   = '0;
                    count_next = '0;
                end else if (core_hlt) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Output decode; every result is registered in the state register block.
    always_comb begin
        we_d    = 1'b0;
        addr_d  = ram_addr;
        wdata_d = ram_wdata;
        if (accept) begin
            we_d    = 1'b1;
            addr_d  = ptr;
            wdata_d = in_data;
        end else if (state == FILL) begin
            we_d    = 1'b1;
            addr_d  = ptr;
            wdata_d = '0;
        end
        // running/done are taken from the next state so they coincide with
        // the final RAM write; core_rst uses the current state and therefore
        // lags one cycle, keeping the core in reset until RAM is complete.
        done_d     = ((state == LOAD) || (state == FILL)) && (state_next == RUN);
        running_d  = (state_next == RUN);
        core_rst_d = (state != RUN);
    end

endmodule

// File: doc/sap1_program_loader.md
# sap1_program_loader

Front-end stage that feeds the SAP-1 core. It accepts a program byte stream from the chip's dedicated inputs over a valid/ready handshake and writes it into the core's 16×8 RAM. Short programs are zero-filled to the end of memory. The core is held in reset throughout loading and released once RAM is fully defined.

## Interface
Parameters:
- `DEPTH`, 16: RAM words; must equal 2**`ADDR_W`
- `ADDR_W`, 4: RAM address width
- `DATA_W`, 8: RAM word width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `load_req`  in  1  level; start a load (IDLE or RUN)
- `start_req`  in  1  level; run existing RAM contents without loading (IDLE only)
- `load_end`  in  1  level; terminate stream early (LOAD only)
- `in_data`  in  `DATA_W`  program byte
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader accepts a byte; combinational, = (state==LOAD)
- `core_hlt`  in  1  HLT flag from core
- `ram_we`  out  1  RAM write strobe, registered
- `ram_addr`  out  `ADDR_W`  RAM write address, registered
- `ram_wdata`  out  `DATA_W`  RAM write data, registered
- `core_rst`  out  1  active-high reset to core, registered
- `running`  out  1  registered, = (state==RUN)
- `done`  out  1  one-cycle pulse on load completion
- `byte_count`  out  `ADDR_W`+1  bytes accepted in last load, 0..`DEPTH`

## Operation
- States: IDLE, LOAD, FILL, RUN. Internal pointer `ptr` (`ADDR_W` bits) and `byte_count`.
- Reset values:
  - state IDLE, `ptr` 0
  - `ram_we`, `ram_addr`, `ram_wdata`: 0
  - `core_rst` 1
  - `running` 0, `done` 0, `byte_count` 0
  - `in_ready` 0 (follows from state)
- IDLE:
  - `load_req` → LOAD; clears `ptr` and `byte_count`.
  - else `start_req` → RUN.
  - `load_req` wins if both are asserted.
- LOAD:
  - Accept when `in_valid & in_ready`. The next cycle drives `ram_we`=1, `ram_addr`=`ptr`, `ram_wdata`=`in_data`.
  - On each accept, `ptr` and `byte_count` increment.
  - The `DEPTH`-th accept → RUN directly; `ptr` wraps to 0.
  - `load_end` → FILL. If `load_end` and an accept occur in the same cycle, the byte is written first and FILL starts at the following address.
  - If `load_end` coincides with the `DEPTH`-th accept → RUN; FILL is skipped.
  - `load_req` and `start_req` are ignored.
- FILL:
  - Each cycle writes 0 at `ptr`, then increments `ptr`.
  - After writing address `DEPTH`-1 → RUN.
  - `in_ready`=0; all requests are ignored.
- RUN:
  - `core_hlt`=1 → IDLE.
  - `load_req`=1 → LOAD; `ptr` and `byte_count` cleared.
  - If both are asserted, `load_req` wins.
  - `start_req` is ignored.
- `core_rst` is registered (state != RUN): it deasserts one cycle after entering RUN and reasserts one cycle after leaving RUN.
- `done` pulses for one cycle, registered, on any transition LOAD→RUN or FILL→RUN. There is no pulse for IDLE→RUN via `start_req`.
- `rst` during LOAD or FILL: returns to IDLE next edge with `ram_we`=0. Partially written RAM is left as is.

## Timing
- Byte accepted at edge N → RAM write visible during cycle N+1 (latency 1).
- Throughput: 1 byte/cycle when `in_valid` is held high; full 16-byte load takes 16 accept cycles.
- Final write (last data byte or last zero-fill) occurs in cycle K. `done`=1 and `running`=1 in cycle K, and `core_rst` falls at edge K+1. The core therefore never runs before its RAM is complete.
- FILL after `load_end` with j bytes loaded takes `DEPTH`−j cycles. With j=0 it takes 16 cycles and writes all zeros.
- `ram_we` is never asserted outside the cycle following an accept or a FILL cycle.

## Test plan
- Reset, then hold `rst`=1 for 2 cycles:
  - `core_rst`=1, `ram_we`=0, `in_ready`=0, `byte_count`=0, `running`=0.
- Full load: `load_req`, then 16 bytes 0x10..0x1F streamed with `in_valid` held high:
  - addresses 0..15 written with 0x10..0x1F, one per cycle.
  - `done` pulses once, `byte_count`=16, `core_rst` falls one cycle after the last write.
- Short load: bytes 0xA1,0xB2,0xC3 with `load_end` asserted alongside 0xC3:
  - addresses 0..2 = A1,B2,C3, then 13 zero writes at addresses 3..15.
  - `byte_count`=3, `done` on the last fill write.
- Back-pressure gaps: `in_valid` toggles 1,0,0,1 across the stream:
  - writes only follow accepts, addresses remain contiguous, `in_ready` stays 1 in LOAD.
- Run/halt/reload: `start_req` from IDLE → `core_rst`=0 with no `done`. Then:
  - `core_hlt` → IDLE and `core_rst`=1.
  - `load_req` during RUN → LOAD, `core_rst`=1 next cycle, `byte_count` cleared.
- `rst` after 5 bytes of a load:
  - IDLE next edge, `ram_we`=0, `in_ready`=0, `core_rst`=1.
  - A new load restarts at address 0.
